// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write-through bypass and pending-write scoreboard
//
// Purpose: ID-stage register file. NR combinational read ports with bypass
// from two write ports (port 1 wins), a debug read port that shows the stored
// array only, and one pending bit per register. A register's pending bit is
// set when a producer issues and cleared when that producer writes back. The
// hazard unit stalls consumers on rbusy. Entry 0 always reads zero.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   raddr  [NR*ADDR_W]          read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata  [NR*DATA_W]          read data, port i at [i*DATA_W +: DATA_W]
//   rbusy  [NR]                 read register has a producer still in flight
//   wen0/waddr0/wdata0          write port 0 (lower priority)
//   wen1/waddr1/wdata1          write port 1 (higher priority)
//   iss_en, iss_addr            a producer of iss_addr issues this cycle
//   wconf                       previous cycle had a same-register double write
//   debug_addr, debug_data      debug read of array contents, no bypass

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  output logic [NR-1:0]        rbusy,
  input  logic                 wen0,
  input  logic [ADDR_W-1:0]    waddr0,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic                 wen1,
  input  logic [ADDR_W-1:0]    waddr1,
  input  logic [DATA_W-1:0]    wdata1,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic                 wconf,
  input  logic [ADDR_W-1:0]    debug_addr,
  output logic [DATA_W-1:0]    debug_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 exists only so every address indexes cleanly; it is reset to
  // zero and never written, and all readers force address 0 to zero anyway.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic              wconf_q;
  logic              wconf_d;

  logic we0_eff;
  logic we1_eff;

  assign we0_eff = wen0 && (waddr0 != '0);
  assign we1_eff = wen1 && (waddr1 != '0);

  // Clear on write-back first, then set on issue, so a new producer issuing
  // on the same edge as the old one writing back keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (we0_eff) pending_d[waddr0] = 1'b0;
    if (we1_eff) pending_d[waddr1] = 1'b0;
    if (iss_en && (iss_addr != '0)) pending_d[iss_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign wconf_d = we0_eff && wen1 && (waddr0 == waddr1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      pending_q <= '0;
      wconf_q   <= 1'b0;
    end else begin
      // Port 1 is assigned last so it wins a same-address double write.
      if (we0_eff) mem_q[waddr0] <= wdata0;
      if (we1_eff) mem_q[waddr1] <= wdata1;
      pending_q <= pending_d;
      wconf_q   <= wconf_d;
    end
  end

  assign wconf = wconf_q;

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;

    assign ra   = raddr[g*ADDR_W +: ADDR_W];
    assign hit1 = wen1 && (waddr1 == ra);
    assign hit0 = wen0 && (waddr0 == ra);

    assign rdata[g*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                       hit1       ? wdata1 :
                                       hit0       ? wdata0 :
                                                    mem_q[ra];

    // A write-back presented this cycle forwards its data, so no stall.
    assign rbusy[g] = pending_q[ra] && !hit0 && !hit1;
  end

  assign debug_data = (debug_addr == '0) ? '0 : mem_q[debug_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed scoreboard testbench for regfile_sb

module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             wen0;
  logic [AW-1:0]    waddr0;
  logic [DW-1:0]    wdata0;
  logic             wen1;
  logic [AW-1:0]    waddr1;
  logic [DW-1:0]    wdata1;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             wconf;
  logic [AW-1:0]    debug_addr;
  logic [DW-1:0]    debug_data;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NR(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .wconf      (wconf),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic setr(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    iss_en = 0; iss_addr = '0;
  endtask

  initial begin
    rst_n = 0;
    raddr = '0;
    debug_addr = '0;
    clr_in();
    #12 rst_n = 1;

    // Reset state on every port and every address.
    for (int a = 0; a < (1 << AW); a++) begin
      setr(0, AW'(a)); setr(1, AW'(a)); debug_addr = AW'(a);
      expect_v($sformatf("rst_rd0_a%0d", a), 32'h0);
      expect_v($sformatf("rst_rd1_a%0d", a), 32'h0);
      expect_v($sformatf("rst_busy_a%0d", a), 32'h0);
      expect_v($sformatf("rst_dbg_a%0d", a), 32'h0);
      #1;
      chk(rd(0)); chk(rd(1)); chk({30'b0, rbusy}); chk(debug_data);
    end
    expect_v("rst_wconf", 32'h0);
    chk({31'b0, wconf});

    // Write to r0 is discarded.
    cyc();
    wen0 = 1; waddr0 = 0; wdata0 = 32'hDEADBEEF; setr(0, 0);
    expect_v("r0_same_cycle", 32'h0);
    #1 chk(rd(0));
    cyc();
    clr_in(); debug_addr = 0;
    expect_v("r0_after", 32'h0);
    expect_v("r0_dbg_after", 32'h0);
    expect_v("r0_wconf", 32'h0);
    #1 chk(rd(0)); chk(debug_data); chk({31'b0, wconf});

    // Bypass on port 0 then array read.
    wen0 = 1; waddr0 = 5; wdata0 = 32'h1234; setr(0, 5); debug_addr = 5;
    expect_v("byp_r5", 32'h1234);
    expect_v("dbg_r5_prewrite", 32'h0);
    #1 chk(rd(0)); chk(debug_data);
    cyc();
    clr_in();
    expect_v("arr_r5", 32'h1234);
    expect_v("dbg_r5", 32'h1234);
    #1 chk(rd(0)); chk(debug_data);
    wen0 = 0; waddr0 = 5; wdata0 = 32'h9999;
    expect_v("nobyp_r5", 32'h1234);
    #1 chk(rd(0));
    cyc();
    clr_in();
    expect_v("nobyp_r5_after", 32'h1234);
    #1 chk(rd(0));

    // Double write to r7: port 1 wins, wconf pulses once.
    wen0 = 1; waddr0 = 7; wdata0 = 32'hAAAA;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h5555; setr(1, 7);
    expect_v("dw_byp_r7", 32'h5555);
    expect_v("dw_wconf_same", 32'h0);
    #1 chk(rd(1)); chk({31'b0, wconf});
    cyc();
    clr_in();
    expect_v("dw_arr_r7", 32'h5555);
    expect_v("dw_wconf_pulse", 32'h1);
    #1 chk(rd(1)); chk({31'b0, wconf});
    cyc();
    expect_v("dw_wconf_drop", 32'h0);
    #1 chk({31'b0, wconf});

    // Issue to r3, then write-back via port 1.
    iss_en = 1; iss_addr = 3; setr(0, 3);
    expect_v("iss_r3_same", 32'h0);
    #1 chk({31'b0, rbusy[0]});
    cyc();
    clr_in();
    expect_v("iss_r3_busy", 32'h1);
    #1 chk({31'b0, rbusy[0]});
    cyc();
    expect_v("iss_r3_busy2", 32'h1);
    #1 chk({31'b0, rbusy[0]});
    wen1 = 1; waddr1 = 3; wdata1 = 32'h77;
    expect_v("wb_r3_busy", 32'h0);
    expect_v("wb_r3_data", 32'h77);
    #1 chk({31'b0, rbusy[0]}); chk(rd(0));
    cyc();
    clr_in();
    expect_v("wb_r3_clear", 32'h0);
    expect_v("wb_r3_arr", 32'h77);
    #1 chk({31'b0, rbusy[0]}); chk(rd(0));

    // Issue to r0 is ignored.
    iss_en = 1; iss_addr = 0; setr(0, 0);
    cyc();
    clr_in();
    expect_v("iss_r0_busy", 32'h0);
    #1 chk({31'b0, rbusy[0]});

    // Same-edge issue and write to r9 keeps it pending.
    iss_en = 1; iss_addr = 9; setr(1, 9);
    cyc();
    clr_in();
    expect_v("r9_busy", 32'h1);
    #1 chk({31'b0, rbusy[1]});
    iss_en = 1; iss_addr = 9; wen0 = 1; waddr0 = 9; wdata0 = 32'h99;
    expect_v("r9_wb_cycle_busy", 32'h0);
    #1 chk({31'b0, rbusy[1]});
    cyc();
    clr_in();
    expect_v("r9_still_busy", 32'h1);
    expect_v("r9_data", 32'h99);
    #1 chk({31'b0, rbusy[1]}); chk(rd(1));

    // Load r1..r4, issue to r2, then asynchronous reset between edges.
    for (int r = 1; r <= 4; r++) begin
      wen0 = 1; waddr0 = AW'(r); wdata0 = 32'h11 * r;
      if (r == 4) begin iss_en = 1; iss_addr = 2; end
      cyc();
    end
    clr_in();
    setr(0, 2); setr(1, 4);
    expect_v("pre_rst_r2", 32'h22);
    expect_v("pre_rst_r4", 32'h44);
    expect_v("pre_rst_busy_r2", 32'h1);
    #1 chk(rd(0)); chk(rd(1)); chk({31'b0, rbusy[0]});
    #2 rst_n = 0;
    #1;
    for (int r = 1; r <= 4; r++) begin
      setr(0, AW'(r)); setr(1, AW'(r));
      expect_v($sformatf("arst_rd0_r%0d", r), 32'h0);
      expect_v($sformatf("arst_rd1_r%0d", r), 32'h0);
      expect_v($sformatf("arst_busy_r%0d", r), 32'h0);
      #1 chk(rd(0)); chk(rd(1)); chk({30'b0, rbusy});
    end
    for (int a = 0; a < (1 << AW); a++) begin
      debug_addr = AW'(a);
      expect_v($sformatf("arst_dbg_a%0d", a), 32'h0);
      #1 chk(debug_data);
    end
    expect_v("arst_wconf", 32'h0);
    chk({31'b0, wconf});

    // Writes and issues while in reset are ignored.
    wen0 = 1; waddr0 = 1; wdata0 = 32'h5; iss_en = 1; iss_addr = 1;
    cyc();
    cyc();
    clr_in();
    setr(0, 1); debug_addr = 1;
    expect_v("rst_wr_ignored", 32'h0);
    expect_v("rst_iss_ignored", 32'h0);
    #1 chk(rd(0)); chk({31'b0, rbusy[0]});
    rst_n = 1;
    cyc();
    expect_v("post_rst_r1", 32'h0);
    expect_v("post_rst_busy_r1", 32'h0);
    #1 chk(rd(0)); chk({31'b0, rbusy[0]});

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
